pi_loop_sequencer: RTL

Sequencer and gear-shift controller for the PLL's proportional-integral loop filter. It consumes the bang-bang phase-detector decision stream (`x`) and maintains the integral path. It selects acquisition or tracking gains from an on-chip lock detector and emits a saturated DCO control word with a valid strobe. It sits between the phase detector and the DCO.

---
 rtl/pi_loop_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pi_loop_sequencer.sv
// Bang-bang PI loop-filter sequencer with ACQ/TRACK gear shifting and a saturated DCO word.
// Optional freeze feature (hold port, HOLD state) is enabled by defining PI_LOOP_FREEZE_EN.
module pi_loop_sequencer #(
    parameter int W         = 20,
    parameter int KI_SH_ACQ = 4,
    parameter int KI_SH_TRK = 1,
    parameter int KP_SH_ACQ = 8,
    parameter int KP_SH_TRK = 5,
    parameter int LOCK_WIN  = 16,
    parameter int LOCK_THR  = 12,
    parameter int RUN_MAX   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                x,
    input  logic                x_valid,
`ifdef PI_LOOP_FREEZE_EN
    input  logic                hold,
`endif
    output logic signed [W-1:0] integ,
    output logic signed [W-1:0] ctrl_word,
    output logic                ctrl_valid,
    output logic [1:0]          mode,
    output logic                locked
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACQ   = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int WW = $clog2(LOCK_WIN + 1);
    localparam int RW = $clog2(RUN_MAX + 1);

    localparam logic signed [W+1:0] ONE    = {{(W+1){1'b0}}, 1'b1};
    localparam logic signed [W+1:0] KI_ACQ = ONE <<< KI_SH_ACQ;
    localparam logic signed [W+1:0] KI_TRK = ONE <<< KI_SH_TRK;
    localparam logic signed [W+1:0] KP_ACQ = ONE <<< KP_SH_ACQ;
    localparam logic signed [W+1:0] KP_TRK = ONE <<< KP_SH_TRK;
    localparam logic signed [W+1:0] MAX_V  = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V  = {3'b111, {(W-1){1'b0}}};

    logic [WW-1:0] win_cnt, win_inc, tog_cnt, tog_inc;
    logic [RW-1:0] run_cnt, run_inc;
    logic          prev_x, have_prev, toggle;
`ifdef PI_LOOP_FREEZE_EN
    logic [1:0]    ret_mode;
`endif

    logic signed [W+1:0] ki_step, kp_step, integ_sum, ctrl_sum;
    logic signed [W-1:0] integ_sat, ctrl_sat;

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        if (v > MAX_V)      return MAX_V[W-1:0];
        else if (v < MIN_V) return MIN_V[W-1:0];
        else                return v[W-1:0];
    endfunction

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        ki_step   = (mode == S_TRACK) ? KI_TRK : KI_ACQ;
        kp_step   = (mode == S_TRACK) ? KP_TRK : KP_ACQ;
        integ_sum = $signed({{2{integ[W-1]}}, integ}) + (x ? ki_step : -ki_step);
        integ_sat = sat(integ_sum);
        ctrl_sum  = $signed({{2{integ_sat[W-1]}}, integ_sat}) + (x ? kp_step : -kp_step);
        ctrl_sat  = sat(ctrl_sum);
        toggle    = have_prev && (x != prev_x);
        win_inc   = win_cnt + 1'b1;
        tog_inc   = tog_cnt + WW'(toggle);
        run_inc   = (have_prev && (x == prev_x)) ? run_cnt + 1'b1 : RW'(1);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            integ      <= '0;
            ctrl_word  <= '0;
            ctrl_valid <= 1'b0;
            mode       <= S_IDLE;
            locked     <= 1'b0;
            win_cnt    <= '0;
            tog_cnt    <= '0;
            run_cnt    <= '0;
            prev_x     <= 1'b0;
            have_prev  <= 1'b0;
`ifdef PI_LOOP_FREEZE_EN
            ret_mode   <= S_IDLE;
`endif
        end else begin
            ctrl_valid <= 1'b0;
            if (!en) begin
                mode      <= S_IDLE;
                locked    <= 1'b0;
                win_cnt   <= '0;
                tog_cnt   <= '0;
                run_cnt   <= '0;
                have_prev <= 1'b0;
            end else begin
                case (mode)
                    S_IDLE: mode <= S_ACQ;
                    S_ACQ, S_TRACK: begin
`ifdef PI_LOOP_FREEZE_EN
                        if (hold) begin
                            ret_mode <= mode;
                            mode     <= S_HOLD;
                        end else
`endif
                        if (x_valid) begin
                            integ      <= integ_sat;
                            ctrl_word  <= ctrl_sat;
                            ctrl_valid <= 1'b1;
                            prev_x     <= x;
                            have_prev  <= 1'b1;
                            if (mode == S_ACQ) begin
                                if (win_inc == WW'(LOCK_WIN)) begin
                                    win_cnt <= '0;
                                    tog_cnt <= '0;
                                    if (tog_inc >= WW'(LOCK_THR)) begin
                                        mode   <= S_TRACK;
                                        locked <= 1'b1;
                                    end
                                end else begin
                                    win_cnt <= win_inc;
                                    tog_cnt <= tog_inc;
                                end
                            end else if (run_inc == RW'(RUN_MAX)) begin
                                // Re-entering ACQ: the next sample has no predecessor.
                                mode      <= S_ACQ;
                                locked    <= 1'b0;
                                win_cnt   <= '0;
                                tog_cnt   <= '0;
                                run_cnt   <= '0;
                                have_prev <= 1'b0;
                            end else begin
                                run_cnt <= run_inc;
                            end
                        end
                    end
                    default: begin
`ifdef PI_LOOP_FREEZE_EN
                        if (!hold) mode <= ret_mode;
`else
                        mode <= S_IDLE;
`endif
                    end
                endcase
            end
        end
    end

endmodule
